// File: rtl/p23_rx_uart_cfg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : p23_rx_uart_cfg                                               |
// | Purpose  : Parametrised receive UART. Configurable character length,     |
// |            runtime parity/stop-bit selection, glitch rejection on the    |
// |            start bit, receive FIFO with per-character framing/parity     |
// |            status and a sticky overrun flag.                             |
// | Optional : P23_RX_UART_BREAK_EN - break frames are not stored; they      |
// |            pulse break_det and the receiver waits for the line to rise.  |
// | Ports    : clk, resetn        - clock, async active-low reset            |
// |            rx_in              - serial line (idle high, asynchronous)    |
// |            div                - clocks per bit (0 and 1 act as 2)        |
// |            cfg_parity         - 00/11 none, 01 odd, 10 even              |
// |            cfg_stop2          - check two stop bits                      |
// |            data_rd, err_clr   - FIFO pop strobe, overrun clear           |
// |            data               - FIFO head word, all-ones when empty      |
// |            rx_avail, overrun  - FIFO not empty, sticky drop flag         |
// |            break_det          - one-cycle break pulse                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module p23_rx_uart_cfg #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_W      = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             rx_in,
   input  logic [DIV_W-1:0] div,
   input  logic [1:0]       cfg_parity,
   input  logic             cfg_stop2,
   input  logic             data_rd,
   input  logic             err_clr,
   output logic [31:0]      data,
   output logic             rx_avail,
   output logic             overrun,
   output logic             break_det
);

   localparam int              AW       = $clog2(FIFO_DEPTH);
   localparam int              EW       = DATA_BITS + 2;
   localparam logic [2:0]      LAST_BIT = 3'(DATA_BITS - 1);
   localparam logic [DIV_W:0]  CNT_ONE  = (DIV_W+1)'(1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP1  = 3'd4,
      STOP2  = 3'd5,
      BRK    = 3'd6
   } state_t;

   state_t                 state_q;
   logic [2:0]             sync_q;
   logic [DIV_W:0]         cnt_q;
   logic [DIV_W-1:0]       div_q;
   logic [1:0]             par_q;
   logic                   stop2_q;
   logic [DATA_BITS-1:0]   sh_q;
   logic [2:0]             bit_q;
   logic                   pe_q;
   logic                   fe_q;
   logic                   push_q;
   logic [EW-1:0]          push_word_q;
`ifdef P23_RX_UART_BREAK_EN
   logic                   pbit_q;
   logic                   brk_q;
   logic                   w_is_brk;
`endif

   logic                   rx_s;
   logic                   w_fall;
   logic                   w_tick;
   logic [DIV_W-1:0]       w_div_eff;
   logic                   w_par_en;
   logic                   w_par_exp;
   logic                   w_fe_fin;
   logic                   w_done;

   assign rx_s      = sync_q[2];
   assign w_fall    = sync_q[2] & ~sync_q[1];
   assign w_tick    = (cnt_q == CNT_ONE);
   assign w_div_eff = (div < DIV_W'(2)) ? DIV_W'(2) : div;
   assign w_par_en  = par_q[0] ^ par_q[1];
   // Even parity bit is the XOR of the data; odd parity (01) inverts it.
   assign w_par_exp = (^sh_q) ^ par_q[0];
   // fe_q is still 0 in STOP1, so this covers both one- and two-stop frames.
   assign w_fe_fin  = fe_q | ~rx_s;
   assign w_done    = w_tick & (((state_q == STOP1) & ~stop2_q) | (state_q == STOP2));
`ifdef P23_RX_UART_BREAK_EN
   assign w_is_brk  = (sh_q == '0) & w_fe_fin & (~w_par_en | ~pbit_q);
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         sync_q      <= 3'b111;
         cnt_q       <= '0;
         div_q       <= '0;
         par_q       <= '0;
         stop2_q     <= 1'b0;
         sh_q        <= '0;
         bit_q       <= '0;
         pe_q        <= 1'b0;
         fe_q        <= 1'b0;
         push_q      <= 1'b0;
         push_word_q <= '0;
`ifdef P23_RX_UART_BREAK_EN
         pbit_q      <= 1'b0;
         brk_q       <= 1'b0;
`endif
      end else begin
         sync_q <= {sync_q[1:0], rx_in};
         push_q <= 1'b0;
`ifdef P23_RX_UART_BREAK_EN
         brk_q  <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               if (w_fall) begin
                  div_q   <= w_div_eff;
                  par_q   <= cfg_parity;
                  stop2_q <= cfg_stop2;
                  cnt_q   <= {2'b00, w_div_eff[DIV_W-1:1]};
                  bit_q   <= '0;
                  pe_q    <= 1'b0;
                  fe_q    <= 1'b0;
                  state_q <= START;
               end
            end
            START: begin
               if (w_tick) begin
                  cnt_q   <= {1'b0, div_q};
                  state_q <= rx_s ? IDLE : DATA;
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end
            DATA: begin
               if (w_tick) begin
                  cnt_q <= {1'b0, div_q};
                  sh_q  <= {rx_s, sh_q[DATA_BITS-1:1]};
                  bit_q <= bit_q + 3'd1;
                  if (bit_q == LAST_BIT) begin
                     state_q <= w_par_en ? PARITY : STOP1;
                  end
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end
            PARITY: begin
               if (w_tick) begin
                  cnt_q   <= {1'b0, div_q};
                  pe_q    <= (rx_s != w_par_exp);
`ifdef P23_RX_UART_BREAK_EN
                  pbit_q  <= rx_s;
`endif
                  state_q <= STOP1;
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end
            STOP1: begin
               if (w_tick) begin
                  cnt_q <= {1'b0, div_q};
                  if (stop2_q) begin
                     fe_q    <= ~rx_s;
                     state_q <= STOP2;
                  end
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end
            STOP2: begin
               if (!w_tick) begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end
`ifdef P23_RX_UART_BREAK_EN
            BRK: begin
               if (rx_s) begin
                  state_q <= IDLE;
               end
            end
`endif
            default: state_q <= IDLE;
         endcase

         // Final stop sample: hand the character to the FIFO next cycle and
         // go straight back to IDLE without waiting out the stop bit.
         if (w_done) begin
`ifdef P23_RX_UART_BREAK_EN
            if (w_is_brk) begin
               brk_q   <= 1'b1;
               state_q <= BRK;
            end else begin
               push_q      <= 1'b1;
               push_word_q <= {pe_q, w_fe_fin, sh_q};
               state_q     <= IDLE;
            end
`else
            push_q      <= 1'b1;
            push_word_q <= {pe_q, w_fe_fin, sh_q};
            state_q     <= IDLE;
`endif
         end
      end
   end

`ifdef P23_RX_UART_BREAK_EN
   assign break_det = brk_q;
`else
   assign break_det = 1'b0;
`endif

   // ---------------- receive FIFO ----------------
   logic [EW-1:0] mem_q [FIFO_DEPTH];
   logic [AW:0]   wp_q, rp_q, wp_d, rp_d;
   logic          overrun_q;
   logic          w_empty, w_full, w_pop, w_wr, w_ovf;
   logic [EW-1:0] w_head;
   logic [7:0]    w_char8;

   assign w_empty = (wp_q == rp_q);
   assign w_full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
   assign w_pop   = data_rd & ~w_empty;
   // A push into a full FIFO succeeds only if the head leaves in the same cycle.
   assign w_wr    = push_q & (~w_full | w_pop);
   assign w_ovf   = push_q & w_full & ~w_pop;

   always_comb begin
      wp_d = wp_q + {{AW{1'b0}}, w_wr};
      rp_d = rp_q + {{AW{1'b0}}, w_pop};
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wp_q      <= '0;
         rp_q      <= '0;
         overrun_q <= 1'b0;
      end else begin
         wp_q <= wp_d;
         rp_q <= rp_d;
         if (w_ovf) begin
            overrun_q <= 1'b1;
         end else if (err_clr) begin
            overrun_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) begin
         mem_q[wp_q[AW-1:0]] <= push_word_q;
      end
   end

   assign w_head = mem_q[rp_q[AW-1:0]];

   always_comb begin
      w_char8                  = '0;
      w_char8[DATA_BITS-1:0]   = w_head[DATA_BITS-1:0];
   end

   assign data     = w_empty ? 32'hFFFF_FFFF
                             : {22'd0, w_head[EW-1], w_head[EW-2], w_char8};
   assign rx_avail = ~w_empty;
   assign overrun  = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_p23_rx_uart_cfg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_p23_rx_uart_cfg                                            |
// | Purpose  : Self-checking bench for p23_rx_uart_cfg (DATA_BITS=8,         |
// |            FIFO_DEPTH=4). Directed vector table, hand-written corner     |
// |            sequences and random frames against a queue-based model.     |
// |            Honours P23_RX_UART_BREAK_EN for the break expectations.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_p23_rx_uart_cfg;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        resetn;
   logic        rx_in;
   logic [15:0] div;
   logic [1:0]  cfg_parity;
   logic        cfg_stop2;
   logic        data_rd;
   logic        err_clr;
   logic [31:0] data;
   logic        rx_avail;
   logic        overrun;
   logic        break_det;

   int n_chk   = 0;
   int n_err   = 0;
   int brk_cnt = 0;

   logic [31:0] mq[$];
   logic        mov;

   p23_rx_uart_cfg #(
      .DATA_BITS (8),
      .FIFO_DEPTH(DEPTH),
      .DIV_W     (16)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .rx_in     (rx_in),
      .div       (div),
      .cfg_parity(cfg_parity),
      .cfg_stop2 (cfg_stop2),
      .data_rd   (data_rd),
      .err_clr   (err_clr),
      .data      (data),
      .rx_avail  (rx_avail),
      .overrun   (overrun),
      .break_det (break_det)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (break_det === 1'b1) brk_cnt++;
   end

   initial begin
      #900us;
      $display("FAIL timeout: simulation did not complete, got running expected finished");
      $fatal(1);
   end

   typedef struct {
      logic [7:0]  ch;
      logic [1:0]  par;
      logic        s2;
      logic        badp;
      logic        st1;
      logic        st2;
      logic [15:0] dv;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[11];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic par_en(input logic [1:0] p);
      return (p == 2'b01) || (p == 2'b10);
   endfunction

   // Correct parity bit for a character: even makes the total count of ones
   // even, odd makes it odd.
   function automatic logic good_pbit(input logic [7:0] ch, input logic [1:0] p);
      int ones = 0;
      for (int i = 0; i < 8; i++) ones += ch[i];
      if (p == 2'b10) return logic'(ones % 2);
      return logic'((ones + 1) % 2);
   endfunction

   function automatic logic [31:0] model_word(input logic [7:0] ch, input logic [1:0] p,
                                              input logic s2, input logic badp,
                                              input logic st1, input logic st2);
      logic pe, fe;
      pe = par_en(p) && badp;
      fe = !st1 || (s2 && !st2);
      return {22'd0, pe, fe, ch};
   endfunction

   function automatic logic model_is_break(input logic [7:0] ch, input logic [1:0] p,
                                           input logic s2, input logic badp,
                                           input logic st1, input logic st2);
`ifdef P23_RX_UART_BREAK_EN
      logic fe, pbit;
      fe   = !st1 || (s2 && !st2);
      pbit = good_pbit(ch, p) ^ badp;
      return (ch == 8'h00) && fe && (!par_en(p) || !pbit);
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_push(input logic [31:0] w, input logic is_brk);
      if (!is_brk) begin
         if (mq.size() == DEPTH) mov = 1'b1;
         else mq.push_back(w);
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_avail"}, {31'd0, rx_avail}, {31'd0, mq.size() != 0});
      chk({tag, "_data"}, data, (mq.size() != 0) ? mq[0] : 32'hFFFF_FFFF);
      chk({tag, "_ovr"}, {31'd0, overrun}, {31'd0, mov});
   endtask

   // Drive one frame clock by clock; rd_cyc selects a cycle in which data_rd
   // is raised (-1 for none). The frame is followed by an idle-high gap long
   // enough for the character to reach the FIFO.
   task automatic send(input logic [7:0] ch, input logic [1:0] p, input logic s2,
                       input logic badp, input logic st1, input logic st2,
                       input logic [15:0] dv, input int rd_cyc);
      logic bits[$];
      int   de;
      int   nf;
      de = (dv < 16'd2) ? 2 : int'(dv);
      cfg_parity = p;
      cfg_stop2  = s2;
      div        = dv;
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(ch[i]);
      if (par_en(p)) bits.push_back(good_pbit(ch, p) ^ badp);
      bits.push_back(st1);
      if (s2) bits.push_back(st2);
      nf = bits.size() * de;
      for (int c = 0; c < nf + 2 * de + 6; c++) begin
         @(posedge clk);
         #1;
         rx_in   = (c < nf) ? bits[c / de] : 1'b1;
         data_rd = (c == rd_cyc);
      end
      data_rd = 1'b0;
   endtask

   task automatic pop_one();
      @(posedge clk);
      #1 data_rd = 1'b1;
      @(posedge clk);
      #1 data_rd = 1'b0;
      if (mq.size() != 0) void'(mq.pop_front());
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(posedge clk);
      #1;
   endtask

   initial begin
      resetn     = 1'b0;
      rx_in      = 1'b1;
      div        = 16'd16;
      cfg_parity = 2'b00;
      cfg_stop2  = 1'b0;
      data_rd    = 1'b0;
      err_clr    = 1'b0;
      mov        = 1'b0;

      tbl[0]  = '{8'h55, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 16'd16, 32'h0000_0055};
      tbl[1]  = '{8'hA3, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 16'd16, 32'h0000_02A3};
      tbl[2]  = '{8'hA3, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 16'd16, 32'h0000_00A3};
      tbl[3]  = '{8'h3C, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 16'd8,  32'h0000_013C};
      tbl[4]  = '{8'h3D, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 16'd8,  32'h0000_003D};
      tbl[5]  = '{8'hA3, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 16'd12, 32'h0000_00A3};
      tbl[6]  = '{8'h5A, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1, 16'd5,  32'h0000_025A};
      tbl[7]  = '{8'h7E, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0,  32'h0000_007E};
      tbl[8]  = '{8'h81, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1,  32'h0000_0181};
      tbl[9]  = '{8'h0F, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 16'd3,  32'h0000_030F};
      tbl[10] = '{8'hC3, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 16'd7,  32'h0000_01C3};

      idle(4);
      chk("rst_data", data, 32'hFFFF_FFFF);
      chk("rst_avail", {31'd0, rx_avail}, 32'd0);
      chk("rst_ovr", {31'd0, overrun}, 32'd0);
      chk("rst_brk", {31'd0, break_det}, 32'd0);
      resetn = 1'b1;
      idle(4);

      // ---- directed vector table ----
      for (int v = 0; v < 11; v++) begin
         send(tbl[v].ch, tbl[v].par, tbl[v].s2, tbl[v].badp, tbl[v].st1, tbl[v].st2,
              tbl[v].dv, -1);
         chk($sformatf("vec%0d_avail", v), {31'd0, rx_avail}, 32'd1);
         chk($sformatf("vec%0d_data", v), data, tbl[v].exp);
         pop_one();
         #1;
         chk($sformatf("vec%0d_empty", v), data, 32'hFFFF_FFFF);
      end

      // ---- overrun: five characters into a four-entry FIFO ----
      for (int i = 1; i <= 5; i++) send(8'(i), 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 16'd16, -1);
      chk("ovr_set", {31'd0, overrun}, 32'd1);
      for (int i = 1; i <= 4; i++) begin
         chk($sformatf("ovr_rd%0d", i), data, 32'(i));
         pop_one();
      end
      #1;
      chk("ovr_drained", data, 32'hFFFF_FFFF);
      pop_one();
      #1;
      chk("ovr_empty_pop", {31'd0, rx_avail}, 32'd0);
      @(posedge clk);
      #1 err_clr = 1'b1;
      @(posedge clk);
      #1 err_clr = 1'b0;
      chk("ovr_clr", {31'd0, overrun}, 32'd0);

      // Same again, but pop in the very cycle the fifth character is written:
      // stop sample lands 3 (sync) + 8 (half bit) + 9*16 cycles after the drop.
      for (int i = 1; i <= 4; i++) send(8'(i), 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 16'd16, -1);
      send(8'h05, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 16'd16, 3 + 8 + 9 * 16);
      chk("ovr_coinc_flag", {31'd0, overrun}, 32'd0);
      for (int i = 2; i <= 5; i++) begin
         chk($sformatf("ovr_coinc_rd%0d", i), data, 32'(i));
         pop_one();
      end
      #1;
      chk("ovr_coinc_empty", data, 32'hFFFF_FFFF);

      // ---- start-bit glitch ----
      div = 16'd16; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
      @(posedge clk);
      #1 rx_in = 1'b0;
      idle(3);
      rx_in = 1'b1;
      idle(60);
      chk("glitch_avail", {31'd0, rx_avail}, 32'd0);
      send(8'h5A, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 16'd16, -1);
      chk("glitch_next", data, 32'h0000_005A);
      pop_one();

      // ---- reset in the middle of data bit 4 ----
      @(posedge clk);
      #1 rx_in = 1'b0;
      idle(16);
      rx_in = 1'b1;
      idle(72);
      resetn = 1'b0;
      idle(3);
      resetn = 1'b1;
      idle(250);
      chk("rstmid_avail", {31'd0, rx_avail}, 32'd0);
      chk("rstmid_data", data, 32'hFFFF_FFFF);

      // ---- break: line low for 12 bit times ----
      brk_cnt = 0;
      @(posedge clk);
      #1 rx_in = 1'b0;
      idle(12 * 16);
      rx_in = 1'b1;
      idle(60);
`ifdef P23_RX_UART_BREAK_EN
      chk("brk_pulses", 32'(brk_cnt), 32'd1);
      chk("brk_avail", {31'd0, rx_avail}, 32'd0);
`else
      chk("brk_pulses", 32'(brk_cnt), 32'd0);
      chk("brk_avail", {31'd0, rx_avail}, 32'd1);
      chk("brk_data", data, 32'h0000_0100);
      pop_one();
      #1;
      chk("brk_single", {31'd0, rx_avail}, 32'd0);
`endif

      // ---- random frames against the queue model ----
      mq.delete();
      @(posedge clk);
      #1 err_clr = 1'b1;
      @(posedge clk);
      #1 err_clr = 1'b0;
      mov = 1'b0;
      for (int n = 0; n < 40; n++) begin
         logic [7:0]  ch;
         logic [1:0]  p;
         logic        s2, badp, st1, st2;
         logic [15:0] dv;
         int          nrd;
         ch   = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 9) == 0) ch = 8'h00;
         p    = 2'($urandom_range(0, 3));
         s2   = 1'($urandom_range(0, 1));
         badp = ($urandom_range(0, 3) == 0);
         st1  = ($urandom_range(0, 4) != 0);
         st2  = ($urandom_range(0, 4) != 0);
         dv   = 16'($urandom_range(0, 24));
         send(ch, p, s2, badp, st1, st2, dv, -1);
         model_push(model_word(ch, p, s2, badp, st1, st2),
                    model_is_break(ch, p, s2, badp, st1, st2));
         check_model($sformatf("rnd%0d", n));
         nrd = $urandom_range(0, 2);
         for (int r = 0; r < nrd; r++) begin
            pop_one();
            #1;
            check_model($sformatf("rnd%0d_rd%0d", n, r));
         end
         if ($urandom_range(0, 5) == 0) begin
            @(posedge clk);
            #1 err_clr = 1'b1;
            @(posedge clk);
            #1 err_clr = 1'b0;
            mov = 1'b0;
            check_model($sformatf("rnd%0d_clr", n));
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
